// File: rtl/odo_pkg.sv
// Shared Odo definitions: state/key widths, round-key table and rotation helper.
// Used by the encrypt and decrypt directions so both derive identical round keys.
package odo_pkg;

   localparam int unsigned ODO_STATE_W   = 640;
   localparam int unsigned ODO_KEY_W     = 10;
   localparam int unsigned ODO_ROUND_W   = 8;
   localparam int unsigned ODO_ROUND_LAT = 2;
   localparam int unsigned ODO_KEY_REPS  = ODO_STATE_W / ODO_KEY_W;

   // Round key for a given round index (truncation to 10 bits is the modulus).
   function automatic logic [ODO_KEY_W-1:0] odo_round_key(input logic [ODO_ROUND_W-1:0] round);
      return ODO_KEY_W'(32'(round) * 32'd97 + 32'd13);
   endfunction

   // Rotation distance (1..7) used by a round with the given key.
   function automatic logic [2:0] odo_rot_amt(input logic [ODO_KEY_W-1:0] key);
      return 3'(key % ODO_KEY_W'(7)) + 3'd1;
   endfunction

endpackage

// File: rtl/odo_decrypt_loop_if.sv
// Block-level bus of the Odo decrypt loop.
//  in_valid/in_ready/in_data/in_tag : block input handshake
//  out_valid/out_data/out_tag       : result strobe, no backpressure
//  occupancy                        : blocks currently in the ring
interface odo_decrypt_loop_if #(
   parameter int unsigned TAG_W = 8,
   parameter int unsigned OCC_W = 4
);
   import odo_pkg::*;

   logic                   in_valid;
   logic                   in_ready;
   logic [ODO_STATE_W-1:0] in_data;
   logic [TAG_W-1:0]       in_tag;
   logic                   out_valid;
   logic [ODO_STATE_W-1:0] out_data;
   logic [TAG_W-1:0]       out_tag;
   logic [OCC_W-1:0]       occupancy;

   modport master (
      output in_valid, in_data, in_tag,
      input  in_ready, out_valid, out_data, out_tag, occupancy
   );

   modport slave (
      input  in_valid, in_data, in_tag,
      output in_ready, out_valid, out_data, out_tag, occupancy
   );

endinterface

// File: rtl/odo_inverse_round.sv
// One Odo inverse round: undo the keyed rotation, then strip the replicated key.
//  clk : clock
//  key : round key aligned with in
//  in  : round input state
//  out : round output state, ODO_ROUND_LAT cycles later
// Datapath only, no reset.
module odo_inverse_round
   import odo_pkg::*;
(
   input  logic                   clk,
   input  logic [ODO_KEY_W-1:0]   key,
   input  logic [ODO_STATE_W-1:0] in,
   output logic [ODO_STATE_W-1:0] out
);

   logic [2:0]             rot;
   logic [9:0]             lsh;
   logic [ODO_STATE_W-1:0] rot_q;
   logic [ODO_KEY_W-1:0]   key_q;

   assign rot = odo_rot_amt(key);
   assign lsh = 10'(ODO_STATE_W) - 10'(rot);

   // First register: rotate right; key travels along for the second register.
   always_ff @(posedge clk) begin
      rot_q <= (in >> rot) | (in << lsh);
      key_q <= key;
   end

   // Second register: remove the key pattern.
   always_ff @(posedge clk) begin
      out <= rot_q ^ {ODO_KEY_REPS{key_q}};
   end

endmodule

// File: rtl/odo_decrypt_loop.sv
// Odo decrypt loop: recirculating ring of STAGES inverse rounds applying ROUNDS rounds
// per block with keys in reverse order; up to RING blocks in flight, each with a tag.
//  clk, rst_n : clock, asynchronous active-low reset
//  bus        : slave side of odo_decrypt_loop_if (input handshake, result strobe, occupancy)
module odo_decrypt_loop
   import odo_pkg::*;
#(
   parameter int unsigned ROUNDS    = 84,
   parameter int unsigned STAGES    = 7,
   parameter int unsigned ROUND_LAT = 2,
   parameter int unsigned TAG_W     = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   odo_decrypt_loop_if.slave bus
);

   localparam int unsigned RING   = STAGES * ROUND_LAT;
   localparam int unsigned PASSES = ROUNDS / STAGES;
   localparam int unsigned PASS_W = (PASSES > 1) ? $clog2(PASSES) : 1;
   localparam int unsigned OCC_W  = $clog2(RING + 1);

   if (ROUNDS != PASSES * STAGES) begin : g_bad_rounds
      $error("odo_decrypt_loop: ROUNDS must be a multiple of STAGES");
   end
   if (ROUND_LAT != ODO_ROUND_LAT) begin : g_bad_lat
      $error("odo_decrypt_loop: ROUND_LAT must match odo_inverse_round");
   end

   // Per-slot sideband, shifted alongside the round datapath.
   logic                   sb_valid [RING];
   logic [PASS_W-1:0]      sb_pass  [RING];
   logic [TAG_W-1:0]       sb_tag   [RING];
   logic [ODO_STATE_W-1:0] stage_out [STAGES];

   logic                   head_valid;
   logic                   finishing;
   logic                   ready;
   logic                   accept;
   logic                   nxt_valid;
   logic [PASS_W-1:0]      nxt_pass;
   logic [TAG_W-1:0]       nxt_tag;
   logic [ODO_STATE_W-1:0] nxt_state;

   logic                   out_valid;
   logic [ODO_STATE_W-1:0] out_data;
   logic [TAG_W-1:0]       out_tag;
   logic [OCC_W-1:0]       occupancy;

   // Head decision: recirculate, retire, or refill slot 0 from the input.
   always_comb begin
      head_valid = sb_valid[RING-1];
      finishing  = head_valid && (sb_pass[RING-1] == PASS_W'(PASSES - 1));
      ready      = !head_valid || finishing;
      accept     = bus.in_valid && ready;
      nxt_valid  = 1'b0;
      nxt_pass   = sb_pass[RING-1] + PASS_W'(1);
      nxt_tag    = sb_tag[RING-1];
      nxt_state  = stage_out[STAGES-1];
      if (accept) begin
         nxt_valid = 1'b1;
         nxt_pass  = '0;
         nxt_tag   = bus.in_tag;
         nxt_state = bus.in_data;
      end else if (head_valid && !finishing) begin
         nxt_valid = 1'b1;
      end
   end

   // Slot valid bits are the only ring state that needs reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(RING); i++) sb_valid[i] <= 1'b0;
      end else begin
         sb_valid[0] <= nxt_valid;
         for (int i = 1; i < int'(RING); i++) sb_valid[i] <= sb_valid[i-1];
      end
   end

   always_ff @(posedge clk) begin
      sb_pass[0] <= nxt_pass;
      sb_tag[0]  <= nxt_tag;
      for (int i = 1; i < int'(RING); i++) begin
         sb_pass[i] <= sb_pass[i-1];
         sb_tag[i]  <= sb_tag[i-1];
      end
   end

   // Stage s works on the slot entering ring offset s*ROUND_LAT; its round index
   // counts down from ROUNDS-1 as the block's pass count rises.
   for (genvar s = 0; s < int'(STAGES); s++) begin : g_stage
      logic [PASS_W-1:0]      pass_in;
      logic [ODO_STATE_W-1:0] din;
      logic [ODO_ROUND_W-1:0] rnd;

      if (s == 0) begin : g_first
         assign pass_in = nxt_pass;
         assign din     = nxt_state;
      end else begin : g_next
         assign pass_in = sb_pass[s*ROUND_LAT-1];
         assign din     = stage_out[s-1];
      end

      assign rnd = ODO_ROUND_W'(ROUNDS - 1 - s) - ODO_ROUND_W'(32'(pass_in) * STAGES);

      odo_inverse_round u_round (
         .clk (clk),
         .key (odo_round_key(rnd)),
         .in  (din),
         .out (stage_out[s])
      );
   end

   // Result register and occupancy counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_tag   <= '0;
         occupancy <= '0;
      end else begin
         out_valid <= finishing;
         if (finishing) begin
            out_data <= stage_out[STAGES-1];
            out_tag  <= sb_tag[RING-1];
         end
         if (accept && !finishing) occupancy <= occupancy + OCC_W'(1);
         else if (!accept && finishing) occupancy <= occupancy - OCC_W'(1);
      end
   end

   assign bus.in_ready  = ready;
   assign bus.out_valid = out_valid;
   assign bus.out_data  = out_data;
   assign bus.out_tag   = out_tag;
   assign bus.occupancy = occupancy;

endmodule

// File: tb/tb_odo_decrypt_loop.sv
// Bench for odo_decrypt_loop: blocks are encrypted here by a forward Odo model,
// fed to the ring, and each result is expected to be the original plaintext
// exactly PASSES*RING edges after acceptance, in order, with its tag.
module tb_odo_decrypt_loop;

   localparam int SW   = 640;
   localparam int RING = 14;
   localparam int LAT  = 168;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   odo_decrypt_loop_if #(.TAG_W(8), .OCC_W(4)) bus ();

   odo_decrypt_loop #(.ROUNDS(84), .STAGES(7), .ROUND_LAT(2), .TAG_W(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   // In-flight blocks: accept edge, tag, expected plaintext.
   int            q_k   [$];
   logic [7:0]    q_tag [$];
   logic [SW-1:0] q_pt  [$];

   logic [SW-1:0] cur_pt;
   logic [SW-1:0] cur_ct;
   logic [7:0]    cur_tag;

   task automatic check(input string tag, input logic [SW-1:0] act, input logic [SW-1:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
   endtask

   // Forward Odo: XOR replicated key, rotate left; rounds 0..83 ascending.
   function automatic logic [SW-1:0] enc(input logic [SW-1:0] pt);
      logic [SW-1:0] x;
      logic [9:0]    k;
      int            rot;
      x = pt;
      for (int r = 0; r < 84; r++) begin
         k   = 10'(r * 97 + 13);
         rot = int'(k) % 7 + 1;
         x   = x ^ {64{k}};
         x   = (x << rot) | (x >> (SW - rot));
      end
      return x;
   endfunction

   task automatic new_block(input logic [7:0] tag);
      for (int i = 0; i < SW / 32; i++) cur_pt[i*32 +: 32] = $urandom;
      cur_tag = tag;
      cur_ct  = enc(cur_pt);
   endtask

   // One cycle: compare outputs against the model at the negedge, then offer the
   // current block for the next edge and advance.
   task automatic cycle(input bit want, output bit acc);
      int cnt;
      bit hocc, hfin, exp_ready, exp_ov;
      cnt  = 0;
      hocc = 0;
      hfin = 0;
      foreach (q_k[j]) begin
         int d;
         d = cyc - q_k[j];
         if (d >= 0 && d < LAT) cnt++;
         if (d >= RING - 1 && d <= LAT - 1 && (d - (RING - 1)) % RING == 0) hocc = 1;
         if (d == LAT - 1) hfin = 1;
      end
      exp_ready = !hocc || hfin;
      exp_ov    = (q_k.size() > 0) && (q_k[0] + LAT == cyc);
      check("occupancy", SW'(bus.occupancy), SW'(cnt));
      check("occ_le_ring", SW'(bus.occupancy <= 4'(RING)), SW'(1));
      check("in_ready", SW'(bus.in_ready), SW'(exp_ready));
      check("out_valid", SW'(bus.out_valid), SW'(exp_ov));
      if (exp_ov) begin
         check("out_data", bus.out_data, q_pt[0]);
         check("out_tag", SW'(bus.out_tag), SW'(q_tag[0]));
         void'(q_k.pop_front());
         void'(q_tag.pop_front());
         void'(q_pt.pop_front());
      end
      bus.in_valid = want;
      bus.in_data  = cur_ct;
      bus.in_tag   = cur_tag;
      acc = want && exp_ready;
      if (acc) begin
         q_k.push_back(cyc + 1);
         q_tag.push_back(cur_tag);
         q_pt.push_back(cur_pt);
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      bit acc;
      for (int i = 0; i < n; i++) cycle(1'b0, acc);
   endtask

   task automatic do_reset();
      rst_n        = 1'b0;
      bus.in_valid = 1'b0;
      q_k.delete();
      q_tag.delete();
      q_pt.delete();
      repeat (2) @(negedge clk);
      check("rst_occupancy", SW'(bus.occupancy), SW'(0));
      check("rst_out_valid", SW'(bus.out_valid), SW'(0));
      check("rst_out_data", bus.out_data, SW'(0));
      check("rst_out_tag", SW'(bus.out_tag), SW'(0));
      rst_n = 1'b1;
      @(posedge clk);
      cyc++;
      @(negedge clk);
   endtask

   initial begin
      bit acc;
      int n;
      rst_n        = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      bus.in_tag   = '0;
      cur_pt       = '0;
      cur_ct       = '0;
      cur_tag      = '0;
      @(negedge clk);
      do_reset();

      // Round trip of a known vector.
      for (int i = 0; i < SW / 32; i++) cur_pt[i*32 +: 32] = 32'h0DD0_0000 + 32'(i * 32'h1111);
      cur_tag = 8'h5A;
      cur_ct  = enc(cur_pt);
      cycle(1'b1, acc);
      check("rt_accept", SW'(acc), SW'(1));
      idle(LAT + 4);

      // Fill: tags 0..14 held on in_valid until taken.
      n = 0;
      new_block(8'(n));
      for (int t = 0; t < 400 && n < 15; t++) begin
         cycle(1'b1, acc);
         if (acc) begin
            n++;
            new_block(8'(n));
         end
      end
      check("fill_count", SW'(n), SW'(15));
      idle(LAT + 4);

      // Sparse accepts at relative cycles 0,3,4,11.
      new_block(8'h80);
      for (int t = 0; t < 12; t++) begin
         bit want;
         want = (t == 0 || t == 3 || t == 4 || t == 11);
         cycle(want, acc);
         if (want) begin
            check("sparse_accept", SW'(acc), SW'(1));
            new_block(8'(8'h81 + 8'(t)));
         end
      end
      idle(LAT + 4);

      // Steady stream with random data and tags.
      new_block(8'($urandom));
      for (int t = 0; t < 1000; t++) begin
         cycle(1'b1, acc);
         if (acc) new_block(8'($urandom));
      end
      idle(LAT + 4);

      // Random valid pattern.
      for (int t = 0; t < 300; t++) begin
         cycle(1'($urandom_range(0, 1)), acc);
         if (acc) new_block(8'($urandom));
      end
      idle(LAT + 4);

      // Reset with blocks in flight, then one fresh block.
      for (int t = 0; t < 5; t++) begin
         new_block(8'(8'hC0 + 8'(t)));
         cycle(1'b1, acc);
      end
      idle(75);
      check("inflight_before_rst", SW'(bus.occupancy), SW'(5));
      do_reset();
      idle(320);
      new_block(8'hEE);
      cycle(1'b1, acc);
      check("post_rst_accept", SW'(acc), SW'(1));
      idle(LAT + 4);
      check("queue_drained", SW'(q_k.size()), SW'(0));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
